// File: rtl/mc_pkg.sv
// mc_pkg: state encodings, opcodes and datapath select encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational decode of state and mem_ready into the datapath control word
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
);
  always_comb begin
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMMSH2;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCSource    = PCSRC_ALUOUT;
        PCWriteCond = 1'b1;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle CPU control FSM sequencing memory, IR, PC, register file and ALU muxes
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c, pc_write_cond_c, reg_write_c;
  always_comb begin
    state_d   = S_FETCH;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d      = op;
        state_d   = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                    op == OP_R    ? S_EXEC   :
                    op == OP_BEQ  ? S_BRANCH :
                    op == OP_J    ? S_JUMP   :
                    op == OP_ADDI ? S_ADDIEX : S_FETCH;
        illegal_d = illegal_q | (state_d == S_FETCH);
      end
      S_MEMADR: state_d = op_q == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end
  mc_out_decode u_dec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemRead    (mem_read_c),
    .MemWrite   (mem_write_c),
    .IRWrite    (ir_write_c),
    .PCWrite    (pc_write_c),
    .PCWriteCond(pc_write_cond_c),
    .RegWrite   (reg_write_c),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource)
  );
  assign MemRead     = mem_read_c & rst_n;
  assign MemWrite    = mem_write_c & rst_n;
  assign IRWrite     = ir_write_c & rst_n;
  assign PCWrite     = pc_write_c & rst_n;
  assign PCWriteCond = pc_write_cond_c & rst_n;
  assign RegWrite    = reg_write_c & rst_n;
  assign state       = state_q;
  assign illegal_op  = illegal_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: random and directed checking of mc_control against a microcode-sequence model
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op;
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  int         m_state;
  bit         m_ill;
  int         m_q[$];
  logic [15:0] tbl[16];
  int         lat;
  bit         saw_pcwc, saw_jmp, saw_wr;
  mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mk(bit iord, bit mr, bit mw, bit pcw, bit pcwc, bit rw, bit rd,
                                     bit m2r, bit asa, logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs);
    return {iord, mr, mw, 1'b0, pcw, pcwc, rw, rd, m2r, asa, asb, aop, pcs};
  endfunction
  initial begin
    foreach (tbl[i]) tbl[i] = '0;
    tbl[0]  = mk(0,1,0,0,0,0,0,0,0,2'd1,2'd0,2'd0);
    tbl[1]  = mk(0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0);
    tbl[2]  = mk(0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
    tbl[3]  = mk(1,1,0,0,0,0,0,0,0,2'd0,2'd0,2'd0);
    tbl[4]  = mk(0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0);
    tbl[5]  = mk(1,0,1,0,0,0,0,0,0,2'd0,2'd0,2'd0);
    tbl[6]  = mk(0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0);
    tbl[7]  = mk(0,0,0,0,0,1,1,0,0,2'd0,2'd0,2'd0);
    tbl[8]  = mk(0,0,0,0,1,0,0,0,1,2'd0,2'd1,2'd1);
    tbl[9]  = mk(0,0,0,1,0,0,0,0,0,2'd0,2'd0,2'd2);
    tbl[10] = tbl[2];
    tbl[11] = mk(0,0,0,0,0,1,0,0,0,2'd0,2'd0,2'd0);
  end
  // Each instruction is FETCH, DECODE, then an opcode-specific tail of states.
  always @(posedge clk or negedge rst_n) begin
    int nxt;
    if (!rst_n) begin
      m_q.delete();
      m_state <= 0;
      m_ill   <= 1'b0;
    end else begin
      nxt = m_state;
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) nxt = m_state;
      else if (m_state == 0) nxt = 1;
      else begin
        if (m_state == 1) begin
          case (op)
            6'b100011: m_q = {2, 3, 4};
            6'b101011: m_q = {2, 5};
            6'b000000: m_q = {6, 7};
            6'b000100: m_q = {8};
            6'b000010: m_q = {9};
            6'b001000: m_q = {10, 11};
            default: begin m_q.delete(); m_ill <= 1'b1; end
          endcase
        end
        nxt = m_q.size() > 0 ? m_q.pop_front() : 0;
      end
      m_state <= nxt;
    end
  end
  always @(negedge clk) begin
    logic [15:0] e, a;
    if (chk_en) begin
      e = tbl[m_state[3:0]];
      if (m_state == 0) begin e[12] = mem_ready; e[11] = mem_ready; end
      if (!rst_n) e[14:9] = '0;
      a = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};
      checks++;
      if (a !== e || state !== 4'(m_state) || illegal_op !== m_ill) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got ctl=%h state=%0d ill=%0b want ctl=%h state=%0d ill=%0b",
                 $time, a, state, illegal_op, e, m_state, m_ill);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] o, input logic mr);
    @(posedge clk);
    #1;
    op = o;
    mem_ready = mr;
    @(negedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] o);
    lat = 1;
    saw_pcwc = 0;
    saw_jmp = 0;
    saw_wr = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(o, 1'b1);
      if (state == 4'd0) return;
      lat++;
      saw_pcwc |= PCWriteCond && PCSource == 2'b01;
      saw_jmp  |= PCWrite && PCSource == 2'b10;
      saw_wr   |= RegWrite || MemWrite;
    end
    chk("instr_timeout", lat, -1);
  endtask
  function automatic logic [5:0] pick_op();
    logic [5:0] ops[6];
    int r;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    r = $urandom_range(6, 0);
    return r < 6 ? ops[r] : 6'($urandom);
  endfunction
  initial begin
    logic [19:0] seq;
    logic [4:0]  iord_v, wb_v;
    int          n;
    rst_n = 1'b1;
    op = 6'b100011;
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_irwrite_pcwrite", {IRWrite, PCWrite}, 0);
    chk("rst_iord", IorD, 0);
    chk("rst_alusrcb", ALUSrcB, 1);
    chk("rst_illegal", illegal_op, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_irwrite_pcwrite", {IRWrite, PCWrite}, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(6'b100011, 1'b1);
      seq = {seq[15:0], state};
      iord_v[i] = IorD;
      wb_v[i] = RegWrite & MemtoReg;
    end
    chk("lw_states", int'(seq), 20'h12340);
    chk("lw_iord", iord_v, 5'b00100);
    chk("lw_wb", wb_v, 5'b01000);
    cyc(6'b101011, 1'b1);
    cyc(6'b101011, 1'b1);
    n = 0;
    repeat (3) begin cyc(6'($urandom), 1'b0); n += int'(MemWrite & IorD); end
    cyc(6'($urandom), 1'b1);
    n += int'(MemWrite & IorD);
    chk("sw_stall_cycles", n, 4);
    cyc(6'($urandom), 1'b1);
    chk("sw_back_fetch", state, 0);
    run_instr(6'b000000); chk("r_latency", lat, 4);
    run_instr(6'b000100); chk("beq_latency", lat, 3); chk("beq_pcwc", saw_pcwc, 1);
    run_instr(6'b000010); chk("j_latency", lat, 3); chk("j_pcwrite", saw_jmp, 1);
    run_instr(6'b001000); chk("addi_latency", lat, 4);
    run_instr(6'b100011); chk("lw_latency", lat, 5);
    run_instr(6'b101011); chk("sw_latency", lat, 4);
    run_instr(6'b111111); chk("ill_latency", lat, 2);
    chk("ill_flag", illegal_op, 1);
    chk("ill_no_write", saw_wr, 0);
    run_instr(6'b001000);
    chk("ill_sticky", illegal_op, 1);
    cyc(6'b100011, 1'b1);
    cyc(6'b100011, 1'b1);
    cyc(6'b100011, 1'b0);
    cyc(6'b100011, 1'b0);
    chk("stall_memrd", state, 3);
    chk("stall_memrd_strobes", {MemRead, IorD}, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_memread_iord", {MemRead, IorD}, 0);
    chk("midrst_illegal", illegal_op, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3000) begin
      cyc(pick_op(), $urandom_range(3, 0) != 0);
      rst_n = $urandom_range(149, 0) != 0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control FSM that sequences the shared instruction/data memory port, including the `IorD` address-select mux, plus the IR, PC, register-file and ALU-operand muxes of the CPU datapath. It decodes the 6-bit opcode held in IR and steps through fetch, decode, execute, memory and write-back states. Memory accesses use a ready handshake so slow memory can stall the sequence. It sits between the instruction register and every datapath select/strobe.

## Interface
- No parameters. State count and encodings are fixed in the package.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from IR[31:26]; sampled only in DECODE.
- `mem_ready` in 1: memory has completed the current read/write this cycle.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite` out 1 each: register enables.
- `RegDst`, `MemtoReg`, `ALUSrcA` out 1 each: datapath mux selects.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state, for debug.
- `illegal_op` out 1: sticky flag; set on an unsupported opcode, cleared only by reset.

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 go to FETCH next cycle.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise hold.
  - DECODE→ by op: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX. Any other op→FETCH and sets `illegal_op`.
  - MEMADR→MEMRD for lw, MEMWR for sw. Op is latched in DECODE into an internal register.
  - MEMRD→MEMWB when `mem_ready`, else hold. MEMWB→FETCH.
  - MEMWR→FETCH when `mem_ready`, else hold.
  - EXEC→ALUWB→FETCH.
  - ADDIEX→ADDIWB→FETCH.
  - BRANCH→FETCH. JUMP→FETCH.
- Outputs are a Moore function of state, except the FETCH enables. Any output not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite = PCWrite = `mem_ready`.
  - DECODE: ALUSrcB=11.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1, MemRead=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1. Both are held until `mem_ready`.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWriteCond=1.
  - JUMP: PCSource=10, PCWrite=1.

## Timing
- Reset (`rst_n`=0):
  - State goes to FETCH asynchronously and `illegal_op`=0.
  - All strobes (MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite) are forced to 0.
  - Selects take FETCH values: IorD=0, ALUSrcB=01, all others 0.
- Reset deasserted mid-instruction: the aborted instruction has no further effect. Fetch restarts from the current PC.
- Latency with `mem_ready` tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes and IorD stay stable throughout the stall.
- `IorD` changes only on state transitions, so it never glitches while MemRead or MemWrite is high.
- `op` is don't-care outside DECODE.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the ALUSrcB, ALUOp and PCSource encodings.
- One sub-module, `mc_out_decode`: a combinational decode from state plus `mem_ready` to the control word.
- The top level holds the state register, the latched op and the `illegal_op` flag.

## Test plan
- Reset sequence: hold `rst_n` low with `mem_ready`=1 → all strobes 0, IorD=0, state=0. Release → IRWrite=PCWrite=1 in the first cycle.
- lw 100011 with `mem_ready`=1 → states 0,1,2,3,4,0. IorD=1 only in state 3. RegWrite and MemtoReg are 1 in state 4.
- sw 101011 with `mem_ready` low for 3 cycles in MEMWR → MemWrite=1 and IorD=1 for 4 cycles, then FETCH.
- R-type, beq and j back to back → cycle counts 4, 3, 3.
  - beq asserts PCWriteCond with PCSource=01.
  - j asserts PCWrite with PCSource=10.
- Illegal op 111111 → DECODE→FETCH, `illegal_op`=1 and sticky. No RegWrite or MemWrite pulse.
- Assert `rst_n` low during MEMRD while stalled → state 0 immediately, MemRead=0, IorD=0.
